pip_cmp: RTL and testbench



---
 rtl/pip_pkg.sv | 11 +
 rtl/pip_stage.sv | 26 ++
 rtl/pip_cmp.sv | 49 ++++
 tb/tb_pip_cmp.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pip_pkg.sv
// Shared constants and types for the branch-compare pipeline register.
package pip_pkg;

    localparam int CMP_W_DEFAULT = 1;
    localparam int PIP_DEPTH_MAX = 8;

    typedef logic [CMP_W_DEFAULT-1:0] cmp_t;

    localparam cmp_t CMP_RST_VAL = '0;

endpackage

// File: rtl/pip_stage.sv
// Single register stage: synchronous active-low reset, hold when en is low.
module pip_stage #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    // Reset takes priority over enable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_reg <= RST_VAL;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pip_cmp.sv
// Branch-compare pipeline register: DEPTH enabled cycles of latency, global stall,
// output taken straight from the last stage flop.
module pip_cmp
    import pip_pkg::*;
#(
    parameter int               WIDTH   = CMP_W_DEFAULT,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(CMP_RST_VAL)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pip_cmp_in,
    input  logic             en,
    output logic [WIDTH-1:0] pip_cmp_out
);

    if (DEPTH < 1 || DEPTH > PIP_DEPTH_MAX || WIDTH < 1) begin : g_bad_param
        $error("pip_cmp: DEPTH must be 1..%0d and WIDTH at least 1", PIP_DEPTH_MAX);
    end

    logic [WIDTH-1:0] stage_reg [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_d;

            if (gi == 0) begin : g_head
                assign stage_d = pip_cmp_in;
            end else begin : g_tail
                assign stage_d = stage_reg[gi-1];
            end

            pip_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
                .en    (en),
                .d     (stage_d),
                .q     (stage_reg[gi])
            );
        end
    endgenerate

    assign pip_cmp_out = stage_reg[DEPTH-1];

endmodule

// File: tb/tb_pip_cmp.sv
// Bench for pip_cmp: a 1-bit single-stage copy and a 4-bit three-stage copy
// share stimulus; a since-reset history queue predicts each output.
module tb_pip_cmp;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [0:0] in1;
    logic [3:0] in3;
    logic [0:0] out1;
    logic [3:0] out3;

    int checks = 0;
    int errors = 0;

    // Values accepted on enabled edges since the last reset, oldest first.
    logic [0:0] hist1[$];
    logic [3:0] hist3[$];

    always #5 clk = ~clk;

    pip_cmp #(.WIDTH(1), .DEPTH(1)) u_d1 (
        .clk         (clk),
        .reset       (reset),
        .pip_cmp_in  (in1),
        .en          (en),
        .pip_cmp_out (out1)
    );

    pip_cmp #(.WIDTH(4), .DEPTH(3)) u_d3 (
        .clk         (clk),
        .reset       (reset),
        .pip_cmp_in  (in3),
        .en          (en),
        .pip_cmp_out (out3)
    );

    // Output of a DEPTH-deep register is the value accepted DEPTH enabled edges ago,
    // or the reset value if fewer than DEPTH values have been accepted since reset.
    function automatic logic [0:0] model1();
        return (hist1.size() >= 1) ? hist1[hist1.size()-1] : 1'b0;
    endfunction

    function automatic logic [3:0] model3();
        return (hist3.size() >= 3) ? hist3[hist3.size()-3] : 4'h0;
    endfunction

    // Apply inputs, take one rising edge, update history, settle 1 time unit.
    task automatic step(input logic r, input logic e, input logic [0:0] d1, input logic [3:0] d3);
        reset = r;
        en    = e;
        in1   = d1;
        in3   = d3;
        @(posedge clk);
        if (!r) begin
            hist1.delete();
            hist3.delete();
        end else if (e) begin
            hist1.push_back(d1);
            hist3.push_back(d3);
            if (hist1.size() > 8) void'(hist1.pop_front());
            if (hist3.size() > 8) void'(hist3.pop_front());
        end
        #1;
        $display("t=%0t reset=%b en=%b in1=%b in3=%h -> out1=%b out3=%h",
                 $time, r, e, d1, d3, out1, out3);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 4'hF);
        checks++;
        if (out1 !== 1'b0) begin
            errors++; $display("FAIL reset_hold_d1: got %b expected %b", out1, 1'b0);
        end
        checks++;
        if (out3 !== 4'h0) begin
            errors++; $display("FAIL reset_hold_d3: got %h expected %h", out3, 4'h0);
        end
        step(1'b1, 1'b0, 1'b1, 4'hF);
        checks++;
        if (out1 !== 1'b0) begin
            errors++; $display("FAIL reset_release_stall: got %b expected %b", out1, 1'b0);
        end
    endtask

    task automatic test_capture();
        step(1'b1, 1'b1, 1'b1, 4'h1);
        checks++;
        if (out1 !== 1'b1) begin
            errors++; $display("FAIL capture_one: got %b expected %b", out1, 1'b1);
        end
        step(1'b1, 1'b1, 1'b0, 4'h2);
        checks++;
        if (out1 !== 1'b0) begin
            errors++; $display("FAIL capture_zero: got %b expected %b", out1, 1'b0);
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b1, 1'b1, 4'h3);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'(i & 1), 4'(i));
            checks++;
            if (out1 !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d]: got %b expected %b", i, out1, 1'b1);
            end
        end
        step(1'b1, 1'b1, 1'b0, 4'h4);
        checks++;
        if (out1 !== 1'b0) begin
            errors++; $display("FAIL stall_resume: got %b expected %b", out1, 1'b0);
        end
    endtask

    task automatic test_reset_priority();
        step(1'b1, 1'b1, 1'b1, 4'h7);
        checks++;
        if (out1 !== 1'b1) begin
            errors++; $display("FAIL prio_preload: got %b expected %b", out1, 1'b1);
        end
        step(1'b0, 1'b1, 1'b1, 4'h7);
        checks++;
        if (out1 !== 1'b0) begin
            errors++; $display("FAIL prio_reset_d1: got %b expected %b", out1, 1'b0);
        end
        checks++;
        if (out3 !== 4'h0) begin
            errors++; $display("FAIL prio_reset_d3: got %h expected %h", out3, 4'h0);
        end
    endtask

    task automatic test_depth();
        logic [3:0] seq [3];
        seq[0] = 4'hA; seq[1] = 4'h5; seq[2] = 4'hF;
        step(1'b1, 1'b1, 1'b0, seq[0]);
        step(1'b1, 1'b1, 1'b0, seq[1]);
        step(1'b1, 1'b1, 1'b0, seq[2]);
        checks++;
        if (out3 !== 4'hA) begin
            errors++; $display("FAIL depth_edge3: got %h expected %h", out3, 4'hA);
        end
        step(1'b1, 1'b1, 1'b0, 4'h0);
        checks++;
        if (out3 !== 4'h5) begin
            errors++; $display("FAIL depth_edge4: got %h expected %h", out3, 4'h5);
        end
        step(1'b1, 1'b1, 1'b0, 4'h0);
        checks++;
        if (out3 !== 4'hF) begin
            errors++; $display("FAIL depth_edge5: got %h expected %h", out3, 4'hF);
        end
        // Same sequence with a one-cycle stall after the second value.
        step(1'b1, 1'b1, 1'b0, seq[0]);
        step(1'b1, 1'b1, 1'b0, seq[1]);
        step(1'b1, 1'b0, 1'b0, 4'h9);
        checks++;
        if (out3 !== 4'h0) begin
            errors++; $display("FAIL depth_stall_edge3: got %h expected %h", out3, 4'h0);
        end
        step(1'b1, 1'b1, 1'b0, seq[2]);
        checks++;
        if (out3 !== 4'hA) begin
            errors++; $display("FAIL depth_stall_edge4: got %h expected %h", out3, 4'hA);
        end
        step(1'b1, 1'b1, 1'b0, 4'h0);
        checks++;
        if (out3 !== 4'h5) begin
            errors++; $display("FAIL depth_stall_edge5: got %h expected %h", out3, 4'h5);
        end
        step(1'b1, 1'b1, 1'b0, 4'h0);
        checks++;
        if (out3 !== 4'hF) begin
            errors++; $display("FAIL depth_stall_edge6: got %h expected %h", out3, 4'hF);
        end
    endtask

    task automatic test_midstream_reset();
        step(1'b1, 1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b1, 1'b1, 4'h2);
        step(1'b1, 1'b1, 1'b1, 4'h3);
        checks++;
        if (out3 !== 4'h1) begin
            errors++; $display("FAIL mid_full: got %h expected %h", out3, 4'h1);
        end
        step(1'b0, 1'b1, 1'b1, 4'hC);
        checks++;
        if (out3 !== 4'h0) begin
            errors++; $display("FAIL mid_reset: got %h expected %h", out3, 4'h0);
        end
        step(1'b1, 1'b1, 1'b0, 4'h7);
        checks++;
        if (out3 !== 4'h0) begin
            errors++; $display("FAIL mid_after1: got %h expected %h", out3, 4'h0);
        end
        step(1'b1, 1'b1, 1'b0, 4'h8);
        checks++;
        if (out3 !== 4'h0) begin
            errors++; $display("FAIL mid_after2: got %h expected %h", out3, 4'h0);
        end
        step(1'b1, 1'b1, 1'b0, 4'h9);
        checks++;
        if (out3 !== 4'h7) begin
            errors++; $display("FAIL mid_after3: got %h expected %h", out3, 4'h7);
        end
    endtask

    task automatic test_random();
        logic [0:0] e1;
        logic [3:0] e3;
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom), 4'($urandom));
            e1 = model1();
            e3 = model3();
            checks++;
            if (out1 !== e1) begin
                errors++; $display("FAIL rand_d1[%0d]: got %b expected %b", i, out1, e1);
            end
            checks++;
            if (out3 !== e3) begin
                errors++; $display("FAIL rand_d3[%0d]: got %h expected %h", i, out3, e3);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        in1   = '0;
        in3   = '0;
        test_reset();
        test_capture();
        test_stall();
        test_reset_priority();
        test_depth();
        test_midstream_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
